// File: rtl/spatial_sram_scheduler.sv
// Round-robin arbiter and row sequencer for the shared projection/item-memory
// SRAM read port; one modality burst at a time, responses steered to the owner.
module spatial_sram_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int MOD1_BASE  = 0,
  parameter int MOD1_LEN   = 64,
  parameter int MOD2_BASE  = 64,
  parameter int MOD2_LEN   = 64,
  parameter int MOD3_BASE  = 128,
  parameter int MOD3_LEN   = 64
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  input  logic [2:0]            Req_SI,
  output logic [2:0]            Grant_SO,
  output logic [2:0]            Done_SO,
  output logic                  Busy_SO,
  output logic                  SramValid_SO,
  input  logic                  SramReady_SI,
  output logic [ADDR_WIDTH-1:0] SramAddr_DO,
  input  logic                  SramRspValid_SI,
  output logic                  SramRspReady_SO,
  output logic [2:0]            RspValid_SO,
  input  logic [2:0]            RspReady_SI,
  output logic [ADDR_WIDTH-1:0] Index_DO,
  output logic                  Last_SO,
  output logic [1:0]            DbgState_DO
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and once raised, valid and its
  // payload (address / index / last) hold until that transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(MOD1_BASE);
  localparam logic [ADDR_WIDTH-1:0] BASE2 = ADDR_WIDTH'(MOD2_BASE);
  localparam logic [ADDR_WIDTH-1:0] BASE3 = ADDR_WIDTH'(MOD3_BASE);
  // Store LEN-1 so a full 2^ADDR_WIDTH-row window still fits in the register.
  localparam logic [ADDR_WIDTH-1:0] LAST1 = ADDR_WIDTH'(MOD1_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST2 = ADDR_WIDTH'(MOD2_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST3 = ADDR_WIDTH'(MOD3_LEN - 1);

  state_e                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_next;
  logic [2:0]              grant_q, pick;
  logic [ADDR_WIDTH-1:0]   count_q, base_q, last_q;
  logic [ADDR_WIDTH-1:0]   base_sel, last_sel;
  logic                    is_last, req_hs, rsp_hs;

  // Rotating priority: first requester at or above ptr, wrapping mod 3.
  always_comb begin
    pick = 3'b000;
    unique case (ptr_q)
      2'd1: begin
        if      (Req_SI[1]) pick = 3'b010;
        else if (Req_SI[2]) pick = 3'b100;
        else if (Req_SI[0]) pick = 3'b001;
      end
      2'd2: begin
        if      (Req_SI[2]) pick = 3'b100;
        else if (Req_SI[0]) pick = 3'b001;
        else if (Req_SI[1]) pick = 3'b010;
      end
      default: begin
        if      (Req_SI[0]) pick = 3'b001;
        else if (Req_SI[1]) pick = 3'b010;
        else if (Req_SI[2]) pick = 3'b100;
      end
    endcase
  end

  always_comb begin
    base_sel = BASE1;
    last_sel = LAST1;
    unique case (pick)
      3'b010: begin
        base_sel = BASE2;
        last_sel = LAST2;
      end
      3'b100: begin
        base_sel = BASE3;
        last_sel = LAST3;
      end
      default: begin
        base_sel = BASE1;
        last_sel = LAST1;
      end
    endcase
  end

  always_comb begin
    ptr_next = 2'd0;
    unique case (grant_q)
      3'b001:  ptr_next = 2'd1;
      3'b010:  ptr_next = 2'd2;
      default: ptr_next = 2'd0;
    endcase
  end

  assign is_last = (count_q == last_q);
  assign req_hs  = (state_q == REQ) && SramReady_SI;
  assign rsp_hs  = (state_q == WAIT) && SramRspValid_SI && |(grant_q & RspReady_SI);

  // State register
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|Req_SI) state_d = REQ;
      REQ:     if (req_hs)  state_d = WAIT;
      WAIT:    if (rsp_hs)  state_d = is_last ? DONE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping: grant, window and row counter
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      ptr_q   <= 2'd0;
      grant_q <= 3'b000;
      base_q  <= '0;
      last_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|Req_SI) begin
            grant_q <= pick;
            base_q  <= base_sel;
            last_q  <= last_sel;
            count_q <= '0;
          end
        end
        WAIT: begin
          if (rsp_hs && !is_last) count_q <= count_q + 1'b1;
        end
        DONE: begin
          ptr_q   <= ptr_next;
          grant_q <= 3'b000;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    SramValid_SO    = (state_q == REQ);
    SramAddr_DO     = base_q + count_q;
    RspValid_SO     = 3'b000;
    SramRspReady_SO = 1'b0;
    Last_SO         = 1'b0;
    Done_SO         = 3'b000;
    if (state_q == WAIT) begin
      RspValid_SO     = grant_q & {3{SramRspValid_SI}};
      SramRspReady_SO = |(grant_q & RspReady_SI);
      Last_SO         = is_last;
    end
    if (state_q == DONE) Done_SO = grant_q;
  end

  assign Grant_SO    = grant_q;
  assign Busy_SO     = (state_q != IDLE);
  assign Index_DO    = count_q;
  assign DbgState_DO = state_q;

endmodule

// File: tb/tb_spatial_sram_scheduler.sv
// Bench for spatial_sram_scheduler: cycle table, directed burst sequences and a
// randomized run scored against a transaction-level reference model.
module tb_spatial_sram_scheduler;

  localparam int AW  = 8;
  localparam int LEN = 4;

  logic          Clk_CI = 1'b0;
  logic          Reset_RI;
  logic [2:0]    Req_SI, Grant_SO, Done_SO, RspValid_SO, RspReady_SI;
  logic          Busy_SO, SramValid_SO, SramReady_SI, SramRspValid_SI;
  logic          SramRspReady_SO, Last_SO;
  logic [AW-1:0] SramAddr_DO, Index_DO;
  logic [1:0]    DbgState_DO;

  spatial_sram_scheduler #(
    .ADDR_WIDTH(AW),
    .MOD1_BASE(0),  .MOD1_LEN(LEN),
    .MOD2_BASE(16), .MOD2_LEN(LEN),
    .MOD3_BASE(32), .MOD3_LEN(LEN)
  ) dut (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .Req_SI(Req_SI), .Grant_SO(Grant_SO),
    .Done_SO(Done_SO), .Busy_SO(Busy_SO), .SramValid_SO(SramValid_SO),
    .SramReady_SI(SramReady_SI), .SramAddr_DO(SramAddr_DO),
    .SramRspValid_SI(SramRspValid_SI), .SramRspReady_SO(SramRspReady_SO),
    .RspValid_SO(RspValid_SO), .RspReady_SI(RspReady_SI), .Index_DO(Index_DO),
    .Last_SO(Last_SO), .DbgState_DO(DbgState_DO)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk_CI = ~Clk_CI;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]    req;
    logic [2:0]    grant;
    logic          valid;
    logic [AW-1:0] addr;
    logic [2:0]    rspv;
    logic [AW-1:0] idx;
    logic          last;
    logic [2:0]    done;
    logic          busy;
  } vec_t;

  vec_t vecs[12];

  // scoreboard and reference-model state
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] idx_q[$];
  logic [AW-1:0] got;
  logic [2:0]    req_prev, prev_grant, mgrant, exp_g, drop_mask;
  logic          pending, hs_req, hs_rsp;
  int            mptr, delay, n_done, quiet, busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] grant,
                              input logic valid, input logic [AW-1:0] addr,
                              input logic [2:0] rspv, input logic [AW-1:0] idx,
                              input logic last, input logic [2:0] done, input logic busy);
    vec_t v;
    v.req = req; v.grant = grant; v.valid = valid; v.addr = addr; v.rspv = rspv;
    v.idx = idx; v.last = last; v.done = done; v.busy = busy;
    return v;
  endfunction

  // reference arbitration: first requester from ptr upward, mod 3
  function automatic logic [2:0] arb(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (r[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  function automatic int gidx(input logic [2:0] g);
    return g[0] ? 0 : (g[1] ? 1 : 2);
  endfunction

  function automatic int base_of(input int m);
    return 16 * m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, Grant_SO, 0);
    chk({tag, "_done"}, Done_SO, 0);
    chk({tag, "_busy"}, Busy_SO, 0);
    chk({tag, "_sram_valid"}, SramValid_SO, 0);
    chk({tag, "_sram_addr"}, SramAddr_DO, 0);
    chk({tag, "_sram_rsp_ready"}, SramRspReady_SO, 0);
    chk({tag, "_rsp_valid"}, RspValid_SO, 0);
    chk({tag, "_index"}, Index_DO, 0);
    chk({tag, "_last"}, Last_SO, 0);
    chk({tag, "_state"}, DbgState_DO, 0);
  endtask

  task automatic do_reset();
    Reset_RI = 1'b1;
    Req_SI = 3'b000; SramReady_SI = 1'b0; SramRspValid_SI = 1'b0; RspReady_SI = 3'b000;
    #1;
    check_zero("reset");
    @(negedge Clk_CI);
    @(negedge Clk_CI);
    Reset_RI = 1'b0;
    SramReady_SI = 1'b1; SramRspValid_SI = 1'b1; RspReady_SI = 3'b111;
  endtask

  task automatic wait_grant(input logic [2:0] g);
    int t;
    t = 0;
    while (Grant_SO == 3'b000 && t < 20) begin
      @(negedge Clk_CI);
      t++;
    end
    chk("grant", Grant_SO, g);
  endtask

  // one row: optional request stall, then optional response stall
  task automatic do_row(input int r, input logic [2:0] g, input int base,
                        input int req_stall, input int rsp_stall);
    SramReady_SI = (req_stall == 0);
    for (int k = 0; k < req_stall; k++) begin
      #1;
      chk("stall_valid", SramValid_SO, 1);
      chk("stall_addr", SramAddr_DO, base + r);
      chk("stall_index", Index_DO, r);
      @(negedge Clk_CI);
    end
    SramReady_SI = 1'b1;
    #1;
    chk("req_valid", SramValid_SO, 1);
    chk("req_addr", SramAddr_DO, base + r);
    chk("req_rsp_valid", RspValid_SO, 0);
    @(negedge Clk_CI);
    RspReady_SI = ~g;
    for (int k = 0; k < rsp_stall; k++) begin
      #1;
      chk("bp_rsp_valid", RspValid_SO, g);
      chk("bp_sram_rsp_ready", SramRspReady_SO, 0);
      chk("bp_index", Index_DO, r);
      chk("bp_last", Last_SO, r == LEN - 1);
      @(negedge Clk_CI);
    end
    RspReady_SI = 3'b111;
    #1;
    chk("rsp_valid", RspValid_SO, g);
    chk("rsp_sram_ready", SramRspReady_SO, 1);
    chk("rsp_index", Index_DO, r);
    chk("rsp_last", Last_SO, r == LEN - 1);
    chk("rsp_sram_valid", SramValid_SO, 0);
    @(negedge Clk_CI);
  endtask

  task automatic run_burst(input logic [2:0] g, input int base, input logic [2:0] req_mid,
                           input logic [2:0] req_done, input int req_stall_row,
                           input int rsp_stall_row);
    wait_grant(g);
    for (int r = 0; r < LEN; r++) begin
      do_row(r, g, base, (r == req_stall_row) ? 3 : 0, (r == rsp_stall_row) ? 2 : 0);
      if (r == 0) Req_SI = req_mid;
    end
    #1;
    chk("done_pulse", Done_SO, g);
    chk("done_busy", Busy_SO, 1);
    chk("done_sram_valid", SramValid_SO, 0);
    @(negedge Clk_CI);
    Req_SI = req_done;
    #1;
    chk("after_done_pulse", Done_SO, 0);
    chk("after_done_busy", Busy_SO, 0);
    chk("after_done_grant", Grant_SO, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    // single request, no stalls: cycle-by-cycle table
    vecs[0] = mk(3'b001, 3'b000, 0, 8'd0, 3'b000, 8'd0, 0, 3'b000, 0);
    for (int r = 0; r < LEN; r++) begin
      vecs[1 + 2*r] = mk(3'b001, 3'b001, 1, 8'(r), 3'b000, 8'(r), 0, 3'b000, 1);
      vecs[2 + 2*r] = mk(3'b001, 3'b001, 0, 8'(r), 3'b001, 8'(r), r == LEN - 1, 3'b000, 1);
    end
    vecs[9]  = mk(3'b001, 3'b001, 0, 8'd3, 3'b000, 8'd3, 0, 3'b001, 1);
    vecs[10] = mk(3'b000, 3'b000, 0, 8'd3, 3'b000, 8'd3, 0, 3'b000, 0);
    vecs[11] = mk(3'b000, 3'b000, 0, 8'd3, 3'b000, 8'd3, 0, 3'b000, 0);

    do_reset();
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      Req_SI = vecs[i].req;
      #1;
      chk($sformatf("v%0d_grant", i), Grant_SO, vecs[i].grant);
      chk($sformatf("v%0d_sram_valid", i), SramValid_SO, vecs[i].valid);
      if (vecs[i].valid) chk($sformatf("v%0d_addr", i), SramAddr_DO, vecs[i].addr);
      chk($sformatf("v%0d_rsp_valid", i), RspValid_SO, vecs[i].rspv);
      chk($sformatf("v%0d_index", i), Index_DO, vecs[i].idx);
      chk($sformatf("v%0d_last", i), Last_SO, vecs[i].last);
      chk($sformatf("v%0d_done", i), Done_SO, vecs[i].done);
      chk($sformatf("v%0d_busy", i), Busy_SO, vecs[i].busy);
      busy_cnt += int'(Busy_SO);
      @(negedge Clk_CI);
    end
    chk("busy_cycles", busy_cnt, 2 * LEN + 1);

    // all three from reset, then ptr wraps back to modality 1
    do_reset();
    Req_SI = 3'b111;
    run_burst(3'b001, 0,  3'b111, 3'b110, -1, -1);
    run_burst(3'b010, 16, 3'b110, 3'b100, -1, -1);
    run_burst(3'b100, 32, 3'b100, 3'b000, -1, -1);
    @(negedge Clk_CI);
    Req_SI = 3'b111;
    run_burst(3'b001, 0, 3'b111, 3'b000, -1, -1);

    // fairness: modality 1 re-requests at once, modality 2 waiting since mid-burst
    do_reset();
    Req_SI = 3'b001;
    run_burst(3'b001, 0,  3'b011, 3'b011, -1, -1);
    run_burst(3'b010, 16, 3'b011, 3'b001, -1, -1);
    run_burst(3'b001, 0,  3'b001, 3'b000, -1, -1);

    // request backpressure at row 2, response backpressure at row 1
    Req_SI = 3'b001;
    run_burst(3'b001, 0, 3'b001, 3'b000, 2, -1);
    Req_SI = 3'b001;
    run_burst(3'b001, 0, 3'b001, 3'b000, -1, 1);

    // reset mid-burst: move ptr away from modality 1, then abandon a burst
    Req_SI = 3'b010;
    run_burst(3'b010, 16, 3'b010, 3'b000, -1, -1);
    Req_SI = 3'b100;
    wait_grant(3'b100);
    do_row(0, 3'b100, 32, 0, 0);
    do_row(1, 3'b100, 32, 0, 0);
    #1;
    chk("pre_reset_addr", SramAddr_DO, 34);
    Req_SI = 3'b101;
    #1;
    Reset_RI = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge Clk_CI);
    Reset_RI = 1'b0;
    run_burst(3'b001, 0, 3'b101, 3'b000, -1, -1);

    // randomized run against the reference model
    do_reset();
    SramRspValid_SI = 1'b0;
    mptr = 0; mgrant = 3'b000; prev_grant = 3'b000; pending = 1'b0;
    hs_req = 1'b0; hs_rsp = 1'b0; drop_mask = 3'b000; quiet = 0; n_done = 0; delay = 0;
    exp_q.delete();
    idx_q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clk_CI);
      req_prev = Req_SI;
      // SRAM responder: one read in flight, 0-2 cycles of latency
      if (hs_rsp) begin
        SramRspValid_SI = 1'b0;
        pending = 1'b0;
      end
      if (hs_req) begin
        pending = 1'b1;
        delay = $urandom_range(0, 2);
      end
      if (pending && !SramRspValid_SI) begin
        if (delay == 0) SramRspValid_SI = 1'b1;
        else delay--;
      end
      SramReady_SI = ($urandom_range(0, 3) != 0);
      RspReady_SI  = 3'($urandom_range(0, 7));
      for (int m = 0; m < 3; m++) begin
        if (drop_mask[m]) Req_SI[m] = (cyc < 3500) && ($urandom_range(0, 3) == 0);
        else if (!Req_SI[m] && cyc < 3500) Req_SI[m] = ($urandom_range(0, 7) == 0);
      end
      drop_mask = 3'b000;
      #1;
      if (prev_grant == 3'b000 && Grant_SO != 3'b000) begin
        exp_g = arb(req_prev, mptr);
        chk("rnd_grant", Grant_SO, exp_g);
        mgrant = exp_g;
        for (int k = 0; k < LEN; k++) begin
          exp_q.push_back(AW'(base_of(gidx(exp_g)) + k));
          idx_q.push_back(AW'(k));
        end
      end
      prev_grant = Grant_SO;
      hs_req = SramValid_SO && SramReady_SI;
      if (hs_req) begin
        chk("rnd_one_outstanding", pending, 0);
        if (exp_q.size() == 0) fail("rnd_unexpected_req");
        else begin
          got = exp_q.pop_front();
          chk("rnd_addr", SramAddr_DO, got);
        end
      end
      if (RspValid_SO != 3'b000)
        chk("rnd_rsp_ready_steer", SramRspReady_SO, |(mgrant & RspReady_SI));
      hs_rsp = SramRspValid_SI && SramRspReady_SO;
      if (hs_rsp) begin
        if (idx_q.size() == 0) fail("rnd_unexpected_rsp");
        else begin
          got = idx_q.pop_front();
          chk("rnd_index", Index_DO, got);
          chk("rnd_last", Last_SO, got == AW'(LEN - 1));
          chk("rnd_rsp_valid", RspValid_SO, mgrant);
        end
      end
      if (Done_SO != 3'b000) begin
        chk("rnd_done", Done_SO, mgrant);
        chk("rnd_done_rows_left", idx_q.size(), 0);
        mptr = (gidx(mgrant) + 1) % 3;
        drop_mask = mgrant;
        n_done++;
      end
      if (hs_req || hs_rsp || (!Busy_SO && Req_SI == 3'b000)) quiet = 0;
      else quiet++;
      if (quiet > 200) begin
        fail("rnd_progress_timeout");
        break;
      end
    end
    chk("rnd_drained_busy", Busy_SO, 0);
    chk("rnd_drained_queue", exp_q.size(), 0);
    chk("rnd_burst_count", n_done > 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
